// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode instruction queue: circular buffer of {ins, pc} entries.
// The head entry is driven combinationally to decode, and NOP_INS is shown whenever the queue is empty.
module fetch_decode_queue #(
   parameter int          DEPTH   = 4,
   parameter logic [31:0] NOP_INS = 32'h00000013
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       PUSH_VALID,
   input  logic [31:0]                PUSH_INS,
   input  logic [63:0]                PUSH_PC,
   input  logic                       INS_CACHE_READY,
   input  logic                       DEC_ADVANCE,
   input  logic                       FLUSH,
   output logic                       PUSH_READY,
   output logic [31:0]                INSTRUCTION,
   output logic [63:0]                PC_OUT,
   output logic                       INS_VALID,
   output logic [$clog2(DEPTH):0]     COUNT
);

   localparam int         AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [31:0]   r_ins_mem [DEPTH];
   logic [63:0]   r_pc_mem  [DEPTH];
   logic [AW-1:0] r_rd_ptr;
   logic [AW-1:0] r_wr_ptr;
   logic [AW:0]   r_count;

   logic w_push;
   logic w_pop;
   logic w_valid;

   // Handshake: an entry moves on an edge only when both sides agree in that cycle.
   // The push side needs PUSH_VALID, INS_CACHE_READY and PUSH_READY together. The pop side needs DEC_ADVANCE and INS_VALID together.
   // PUSH_READY also looks at DEC_ADVANCE so that a full queue can take a push while it pops.
   assign w_valid    = (r_count != '0);
   assign PUSH_READY = (r_count < FULL) | DEC_ADVANCE;
   assign w_push     = PUSH_VALID & INS_CACHE_READY & PUSH_READY & ~FLUSH;
   assign w_pop      = DEC_ADVANCE & w_valid & ~FLUSH;

   assign INS_VALID   = w_valid;
   assign INSTRUCTION = w_valid ? r_ins_mem[r_rd_ptr] : NOP_INS;
   assign PC_OUT      = w_valid ? r_pc_mem[r_rd_ptr]  : 64'd0;
   assign COUNT       = r_count;

   // The storage has no reset. The output muxes hide its contents whenever the queue is empty.
   always_ff @(posedge CLK) begin
      if (w_push) begin
         r_ins_mem[r_wr_ptr] <= PUSH_INS;
         r_pc_mem[r_wr_ptr]  <= PUSH_PC;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (FLUSH) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: a vector table, hand-written corner sequences and a random phase.
// A queue model acts as the scoreboard and is compared against every pop and every post-edge state.
module tb_fetch_decode_queue;

   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h00000013;

   logic        CLK;
   logic        RST;
   logic        PUSH_VALID;
   logic [31:0] PUSH_INS;
   logic [63:0] PUSH_PC;
   logic        INS_CACHE_READY;
   logic        DEC_ADVANCE;
   logic        FLUSH;
   logic        PUSH_READY;
   logic [31:0] INSTRUCTION;
   logic [63:0] PC_OUT;
   logic        INS_VALID;
   logic [2:0]  COUNT;

   int total = 0;
   int bad   = 0;
   logic [95:0] exp_q[$];

   fetch_decode_queue #(.DEPTH(DEPTH), .NOP_INS(NOP)) dut (
      .CLK(CLK), .RST(RST), .PUSH_VALID(PUSH_VALID), .PUSH_INS(PUSH_INS),
      .PUSH_PC(PUSH_PC), .INS_CACHE_READY(INS_CACHE_READY),
      .DEC_ADVANCE(DEC_ADVANCE), .FLUSH(FLUSH), .PUSH_READY(PUSH_READY),
      .INSTRUCTION(INSTRUCTION), .PC_OUT(PC_OUT), .INS_VALID(INS_VALID),
      .COUNT(COUNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: act=%h exp=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_state();
      logic [95:0] h;
      check("count", 64'(COUNT), 64'(exp_q.size()));
      check("ins_valid", 64'(INS_VALID), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         h = exp_q[0];
         check("head_ins", 64'(INSTRUCTION), 64'(h[95:64]));
         check("head_pc", PC_OUT, h[63:0]);
      end else begin
         check("empty_ins", 64'(INSTRUCTION), 64'(NOP));
         check("empty_pc", PC_OUT, 64'd0);
      end
   endtask

   // One clock cycle: drive on the falling edge, check ready and any popped entry, then check the state after the edge.
   task automatic step(input logic pv, input logic [31:0] ins, input logic [63:0] pc,
                       input logic cr, input logic da, input logic fl);
      logic exp_rdy, do_push, do_pop;
      logic [95:0] h;
      @(negedge CLK);
      PUSH_VALID = pv; PUSH_INS = ins; PUSH_PC = pc;
      INS_CACHE_READY = cr; DEC_ADVANCE = da; FLUSH = fl;
      #1;
      exp_rdy = (exp_q.size() < DEPTH) || da;
      check("push_ready", 64'(PUSH_READY), 64'(exp_rdy));
      do_push = pv && cr && exp_rdy && !fl;
      do_pop  = da && (exp_q.size() != 0) && !fl;
      if (do_pop) begin
         h = exp_q[0];
         check("pop_ins", 64'(INSTRUCTION), 64'(h[95:64]));
         check("pop_pc", PC_OUT, h[63:0]);
      end
      @(posedge CLK);
      if (fl) exp_q.delete();
      else begin
         if (do_pop) void'(exp_q.pop_front());
         if (do_push) exp_q.push_back({ins, pc});
      end
      #1;
      check_state();
   endtask

   typedef struct {
      logic        pv;
      logic [31:0] ins;
      logic [63:0] pc;
      logic        cr;
      logic        da;
      logic        fl;
      logic [2:0]  e_cnt;
      logic        e_vld;
      logic [31:0] e_ins;
      logic [63:0] e_pc;
      logic        e_rdy;
   } vec_t;

   vec_t vecs[10];

   localparam logic [31:0] IA = 32'h00A00093, IB = 32'h00100113, IC = 32'h00200193;
   localparam logic [31:0] ID = 32'h00300213, IE = 32'h00400293, IF = 32'h00500313;

   initial begin
      vecs[0] = '{1'b1, IA, 64'h1000, 1'b1, 1'b0, 1'b0, 3'd1, 1'b1, IA, 64'h1000, 1'b1};
      vecs[1] = '{1'b1, IB, 64'h1004, 1'b1, 1'b0, 1'b0, 3'd2, 1'b1, IA, 64'h1000, 1'b1};
      vecs[2] = '{1'b1, IC, 64'h1008, 1'b1, 1'b0, 1'b0, 3'd3, 1'b1, IA, 64'h1000, 1'b1};
      vecs[3] = '{1'b1, ID, 64'h100C, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, IA, 64'h1000, 1'b0};
      vecs[4] = '{1'b1, IE, 64'h1010, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1, IA, 64'h1000, 1'b0};
      vecs[5] = '{1'b1, IE, 64'h1010, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1, IB, 64'h1004, 1'b1};
      vecs[6] = '{1'b0, 32'd0, 64'd0, 1'b1, 1'b1, 1'b0, 3'd3, 1'b1, IC, 64'h1008, 1'b1};
      vecs[7] = '{1'b1, IF, 64'h2000, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1, IC, 64'h1008, 1'b1};
      vecs[8] = '{1'b1, IF, 64'h2000, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0, NOP, 64'd0, 1'b1};
      vecs[9] = '{1'b0, 32'd0, 64'd0, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, NOP, 64'd0, 1'b1};

      RST = 1'b0; PUSH_VALID = 1'b0; PUSH_INS = '0; PUSH_PC = '0;
      INS_CACHE_READY = 1'b0; DEC_ADVANCE = 1'b0; FLUSH = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      check("rst_count", 64'(COUNT), 64'd0);
      check("rst_valid", 64'(INS_VALID), 64'd0);
      check("rst_ins", 64'(INSTRUCTION), 64'(NOP));
      check("rst_pc", PC_OUT, 64'd0);
      check("rst_ready", 64'(PUSH_READY), 64'd1);
      @(negedge CLK);
      RST = 1'b1;

      for (int i = 0; i < 10; i++) begin
         step(vecs[i].pv, vecs[i].ins, vecs[i].pc, vecs[i].cr, vecs[i].da, vecs[i].fl);
         check($sformatf("vec%0d_count", i), 64'(COUNT), 64'(vecs[i].e_cnt));
         check($sformatf("vec%0d_valid", i), 64'(INS_VALID), 64'(vecs[i].e_vld));
         check($sformatf("vec%0d_ins", i), 64'(INSTRUCTION), 64'(vecs[i].e_ins));
         check($sformatf("vec%0d_pc", i), PC_OUT, vecs[i].e_pc);
         check($sformatf("vec%0d_ready", i), 64'(PUSH_READY), 64'(vecs[i].e_rdy));
      end

      // Interleaved push and pop makes the pointers wrap past DEPTH-1.
      for (int i = 0; i < 6; i++)
         step(1'b1, 32'h00000093 + 32'(i), 64'h1000 + 64'(4 * i), 1'b1, (i > 0), 1'b0);
      check("wrap_last_pc", PC_OUT, 64'h1014);
      step(1'b0, 32'd0, 64'd0, 1'b1, 1'b1, 1'b0);
      check("wrap_drained", 64'(COUNT), 64'd0);

      // Reset is asserted between edges while two entries are held.
      step(1'b1, 32'h11111111, 64'h3000, 1'b1, 1'b0, 1'b0);
      step(1'b1, 32'h22222222, 64'h3004, 1'b1, 1'b0, 1'b0);
      @(negedge CLK);
      PUSH_VALID = 1'b0; DEC_ADVANCE = 1'b0;
      #2;
      RST = 1'b0;
      #1;
      check("async_count", 64'(COUNT), 64'd0);
      check("async_valid", 64'(INS_VALID), 64'd0);
      check("async_ins", 64'(INSTRUCTION), 64'(NOP));
      check("async_pc", PC_OUT, 64'd0);
      check("async_ready", 64'(PUSH_READY), 64'd1);
      exp_q.delete();
      @(negedge CLK);
      RST = 1'b1;
      step(1'b1, 32'h33333333, 64'h4000, 1'b1, 1'b0, 1'b0);
      check("post_rst_pc", PC_OUT, 64'h4000);

      for (int i = 0; i < 300; i++)
         step($urandom_range(0, 3) != 0, $urandom, {32'd0, $urandom},
              $urandom_range(0, 4) != 0, $urandom_range(0, 1) == 1,
              $urandom_range(0, 40) == 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
